// File: rtl/leg_solver.sv
// Leg solver: y = isqrt(r*r - x*x) using a restoring square root that resolves one bit per cycle.
// Optional LEG_SOLVER_ROUND_EN rounds the result to nearest instead of truncating.
module leg_solver #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] r,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         err
);

  localparam int unsigned DW = 2 * W;
  localparam int unsigned RW = W + 2;
  localparam int unsigned TW = W + 4;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rad_q, rad_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [W-1:0]  root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [DW-1:0] diff_c;
  logic [TW-1:0] lhs_c, rhs_c;
  logic          fits_c;
  logic [RW-1:0] rem_step_c;
  logic [W-1:0]  root_step_c;
  logic [W-1:0]  y_fin_c;

  // Radicand: the x <= r check guarantees the difference is non-negative.
  always_comb begin
    diff_c = (DW'(r) * DW'(r)) - (DW'(x) * DW'(x));
  end

  // One restoring-sqrt step on the top two radicand bits.
  always_comb begin
    lhs_c       = {rem_q, rad_q[DW-1 -: 2]};
    rhs_c       = TW'({root_q, 2'b01});
    fits_c      = (lhs_c >= rhs_c);
    rem_step_c  = fits_c ? RW'(lhs_c - rhs_c) : RW'(lhs_c);
    root_step_c = W'({root_q, fits_c});
  end

  // Final result; rounding only bumps when the remainder exceeds the root.
  always_comb begin
    y_fin_c = root_step_c;
`ifdef LEG_SOLVER_ROUND_EN
    if (rem_step_c > RW'(root_step_c)) begin
      y_fin_c = root_step_c + W'(1);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (x > r) begin
            err_d       = 1'b1;
            y_d         = '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            err_d   = 1'b0;
            rad_d   = diff_c;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CW'(W - 1);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_step_c;
        root_d = root_step_c;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          y_d         = y_fin_c;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_leg_solver.sv
// Self-checking bench for leg_solver: behavioural isqrt model, per-cycle output monitor, random traffic.
module tb_leg_solver;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r;
  logic [W-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_y   = '0;
  logic         exp_err = 1'b0;

  always #5 clk = ~clk;

  leg_solver #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: largest y with y*y <= r*r - x*x, optionally rounded to nearest.
  function automatic void model(input int rv, input int xv, output int yy, output int ee);
    int d;
    if (xv > rv) begin
      yy = 0;
      ee = 1;
    end else begin
      d  = rv * rv - xv * xv;
      yy = 0;
      while ((yy + 1) * (yy + 1) <= d) yy++;
`ifdef LEG_SOLVER_ROUND_EN
      if (d - yy * yy > yy) yy++;
`endif
      ee = 0;
    end
  endfunction

  // Whenever a result is offered it must match the model and input must be blocked.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("mon_y", int'(y), int'(exp_y));
      chk("mon_err", int'(err), int'(exp_err));
      chk("mon_in_ready_low", int'(in_ready), 0);
    end
  end

  task automatic run(input int rv, input int xv, input int hold, input bit pre_ready,
                     input bit poke, input int lit_y, input int lit_err, input string tag);
    int my, me, lat, guard;
    model(rv, xv, my, me);
    if (lit_y >= 0) begin
      chk({tag, "_model_y"}, my, lit_y);
      chk({tag, "_model_err"}, me, lit_err);
    end
    exp_y     = W'(my);
    exp_err   = 1'(me);
    r         = W'(rv);
    x         = W'(xv);
    out_ready = pre_ready;
    in_valid  = 1'b1;
    guard     = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, (me != 0) ? 1 : int'(W) + 1);
    chk({tag, "_y"}, int'(y), my);
    chk({tag, "_err"}, int'(err), me);
    if (!pre_ready) begin
      if (poke) begin
        r        = W'(9);
        x        = W'(0);
        in_valid = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
      end
      if (poke) chk({tag, "_held_valid"}, int'(out_valid), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, int'(out_valid), 0);
    chk({tag, "_post_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int rv, xv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r         = '0;
    x         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_err", int'(err), 0);

    run(5, 3, 0, 1'b0, 1'b0, 4, 0, "r5x3");
    run(13, 5, 2, 1'b0, 1'b0, 12, 0, "r13x5");
    run(25, 7, 1, 1'b0, 1'b0, 24, 0, "r25x7");
    run(3, 5, 0, 1'b0, 1'b0, 0, 1, "r3x5");
    run(0, 0, 0, 1'b0, 1'b0, 0, 0, "r0x0");
    run(255, 0, 0, 1'b0, 1'b0, 255, 0, "r255x0");
    run(200, 200, 0, 1'b0, 1'b0, 0, 0, "x_eq_r");
`ifdef LEG_SOLVER_ROUND_EN
    run(10, 1, 0, 1'b0, 1'b0, 10, 0, "r10x1");
`else
    run(10, 1, 0, 1'b0, 1'b0, 9, 0, "r10x1");
`endif
    run(1, 0, 0, 1'b0, 1'b0, 1, 0, "r1x0");
    run(6, 2, 0, 1'b1, 1'b0, -1, 0, "pre_ready");
    run(20, 12, 20, 1'b0, 1'b1, 16, 0, "hold20");

    // Abort an operation during CALC; nothing may be emitted afterwards.
    r        = W'(200);
    x        = W'(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_y", int'(y), 0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_output", int'(out_valid), 0);
    run(5, 4, 0, 1'b0, 1'b0, 3, 0, "r5x4");

    for (int n = 0; n < 40; n++) begin
      rv = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) xv = int'($urandom_range(0, 255));
      else xv = int'($urandom_range(0, rv));
      run(rv, xv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, -1, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
